// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit state encoding and 8N1 framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value and a synchronous active-low reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a one-deep holding register read by the CPU.
//   state | meaning
//   IDLE  | waiting for a high-to-low edge on the synchronized line
//   START | counting to mid start bit; a high sample there is a glitch
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | sampling the stop bit; high accepts the byte, low flags a framing error
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

    uart_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_s_prev_q;
    logic            rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (UART_RX),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_s_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_s_prev_q <= rx_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // The read clear is applied first so a same-cycle accept or error overrides it.
        if (rx_ack && rx_valid_q) begin
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_s_prev_q && !rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        if (!rx_valid_q || rx_ack) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Byte-oriented UART receiver for the pipelined CPU's serial peripheral. It terminates the incoming UART_RX line: 8N1 framing, LSB first, mid-bit sampling. Each received byte goes into a one-deep holding register, and the CPU bus logic reads and acknowledges it. It runs in the processor clock domain, alongside the existing transmit path.

## Interface
- CLKS_PER_BIT, default 10, meaning clock cycles per bit period. Must be an integer of at least 4.
- clk  input  1  processor clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset. The block is reset when reset==0 at a rising clk edge.
- UART_RX  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  high while rx_data holds an unread byte.
- rx_ack  input  1  single-cycle read strobe from the CPU. It is ignored when rx_valid==0.
- frame_err  output  1  sticky flag: a stop bit was sampled low.
- overrun  output  1  sticky flag: a byte completed while rx_valid==1 and no rx_ack was present.

## Operation
- Input synchronizer: UART_RX passes through a 2-flop synchronizer giving rx_s. Both flops reset to 1.
- Bit counter: a down-counter of width clog2(CLKS_PER_BIT).
- Bit index: a 3-bit index and an 8-bit shift register (shifts right, new bit into the MSB).
- State machine (4 states):
  - IDLE: rx_s_prev==1 and rx_s==0 gives a falling edge. Load the counter with CLKS_PER_BIT/2-1 (integer division) and go to START.
  - START: when the counter reaches 0, sample rx_s.
    - rx_s==1: glitch, return to IDLE.
    - rx_s==0: load the counter with CLKS_PER_BIT-1, set index=0, go to DATA.
  - DATA: when the counter reaches 0, shift in rx_s and reload the counter. At index==7, go to STOP; otherwise increment the index.
  - STOP: when the counter reaches 0, sample rx_s and go to IDLE.
    - rx_s==1 (accept): see the holding-register rules below.
    - rx_s==0: set frame_err and discard the byte. IDLE then needs a genuine high-to-low edge, so a held break line does not retrigger.
- Holding register rules on accept:
  - rx_valid==0, or rx_ack this cycle: rx_data takes the shift register and rx_valid=1.
  - rx_valid==1 and no rx_ack: the new byte is dropped, rx_data is kept, and overrun=1.
- rx_ack with rx_valid==1: rx_valid, frame_err and overrun all clear on the next edge. An accept in the same cycle wins over the clear for rx_valid: rx_valid stays 1 and holds the new data.
- Reset mid-frame aborts immediately:
  - state=IDLE, synchronizer flops=1;
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.

## Timing
- All outputs are registered. Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0.
- Let E be the edge at which IDLE detects the falling rx_s. E is 2–3 clk after the UART_RX pin falls, depending on synchronizer phase.
- Sample points after E:
  - start bit: CLKS_PER_BIT/2;
  - data bit k: CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- rx_valid rises on the edge after the stop-bit sample.
- The block is ready for a new start edge on the cycle after the stop sample, i.e. about half a bit before the nominal frame end. Back-to-back frames are received without loss.
- rx_ack to rx_valid low: 1 cycle.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the 8N1 constants: DATA_BITS=8, STOP_BITS=1.
- The future transmitter reuses this package.
- Sub-module sync_2ff: a generic 2-flop synchronizer with a reset value parameter, instantiated with reset value 1. Everything else is flat, about 150–200 lines.

## Test plan
All scenarios run with CLKS_PER_BIT=16.
- Single byte: drive frame 8'hA5, then idle high → rx_valid rises exactly 2+8+144+1 clk after the pin falls (±1 for synchronizer phase); rx_data=8'hA5, frame_err=0.
- Glitch rejection: a 4-cycle low pulse on UART_RX → state returns to IDLE, rx_valid stays 0, and a following valid frame 8'h3C is received correctly.
- Framing error and break: frame 8'h55 with stop bit low and the line held low for 64 cycles → frame_err=1, rx_valid=0, no second frame detected. After the line returns high, frame 8'h12 is received; rx_ack then clears frame_err.
- Overrun: send 8'h01 then 8'h02 back-to-back with no rx_ack → rx_data=8'h01, overrun=1. rx_ack → rx_valid=0 and overrun=0 next cycle.
- Simultaneous ack and completion: assert rx_ack in the cycle of the stop sample for the second byte 8'hFE → rx_valid stays 1, rx_data=8'hFE, overrun=0.
- Reset mid-frame: pull reset low during data bit 4 for 1 cycle → all outputs 0 and state IDLE. The remainder of the frame produces no byte unless a new falling edge occurs; the next full frame 8'h7E is received correctly.
